// File: rtl/l2_mem_arbiter.sv
// rtl/l2_mem_arbiter.sv - two-port L2 read/eviction arbiter onto one memory port; define L2ARB_FIXED_PRIORITY_EN for fixed port-0 priority
module l2_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rd_0,
  input  logic              wr_0,
  input  logic [ADDR_W-1:0] addr_0,
  input  logic [LINE_W-1:0] wdata_0,
  input  logic              hold_0,
  output logic [LINE_W-1:0] fill_data_0,
  output logic              fill_valid_0,
  output logic              ovf_0,
  input  logic              rd_1,
  input  logic              wr_1,
  input  logic [ADDR_W-1:0] addr_1,
  input  logic [LINE_W-1:0] wdata_1,
  input  logic              hold_1,
  output logic [LINE_W-1:0] fill_data_1,
  output logic              fill_valid_1,
  output logic              ovf_1,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic              mem_rvalid,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              timeout_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA, RESP} state_t;

  localparam logic [7:0]        CNT_LAST   = 8'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK  = {{(ADDR_W-4){1'b1}}, 4'b0000};

  state_t            state, state_next;
  logic [1:0]        rd_in, wr_in, hold_in;
  logic [ADDR_W-1:0] addr_in [2];
  logic [LINE_W-1:0] wdata_in [2];
  logic [1:0]        rd_v, wr_v, ovf, clr_rd, clr_wr, fill_valid;
  logic [ADDR_W-1:0] rd_addr [2];
  logic [ADDR_W-1:0] wr_addr [2];
  logic [LINE_W-1:0] wr_data [2];
  logic [LINE_W-1:0] fill_data [2];
  logic              last, g_port, g_we, sel_port, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        cnt;
  logic              grant, svc, got, abort, fire;

  assign rd_in       = {rd_1, rd_0};
  assign wr_in       = {wr_1, wr_0};
  assign hold_in     = {hold_1, hold_0};
  assign addr_in[0]  = addr_0;
  assign addr_in[1]  = addr_1;
  assign wdata_in[0] = wdata_0;
  assign wdata_in[1] = wdata_1;

  assign fill_data_0  = fill_data[0];
  assign fill_data_1  = fill_data[1];
  assign fill_valid_0 = fill_valid[0];
  assign fill_valid_1 = fill_valid[1];
  assign ovf_0        = ovf[0];
  assign ovf_1        = ovf[1];

  // Pick the port to serve: the non-last port on a tie, and its write slot before its read slot
  always_comb begin
    sel_port = 1'b0;
    if ((rd_v[1] | wr_v[1]) && !(rd_v[0] | wr_v[0]))
      sel_port = 1'b1;
    else if ((rd_v[1] | wr_v[1]) && (rd_v[0] | wr_v[0]))
      sel_port = ~last;
    sel_we   = wr_v[sel_port];
    sel_addr = sel_we ? wr_addr[sel_port] : rd_addr[sel_port];
  end

`ifdef L2ARB_FIXED_PRIORITY_EN
  assign last = 1'b1;
`else
  // Round-robin pointer follows the most recently granted port
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      last <= 1'b1;
    else if (grant) last <= sel_port;
  end
`endif

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state and per-cycle control strobes
  always_comb begin
    state_next = state;
    grant      = 1'b0;
    svc        = 1'b0;
    got        = 1'b0;
    abort      = 1'b0;
    fire       = 1'b0;
    clr_rd     = '0;
    clr_wr     = '0;
    case (state)
      IDLE: begin
        if ((|rd_v) || (|wr_v)) begin
          grant      = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (mem_ack) begin
          svc = 1'b1;
          if (g_we) begin
            clr_wr[g_port] = 1'b1;
            state_next     = IDLE;
          end else begin
            clr_rd[g_port] = 1'b1;
            state_next     = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        if (mem_rvalid) begin
          got        = 1'b1;
          state_next = RESP;
        end else if (cnt == CNT_LAST) begin
          abort      = 1'b1;
          state_next = RESP;
        end
      end
      RESP: begin
        if (!hold_in[g_port]) begin
          fire       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pending slots: a strobe reloads a slot that is empty or being cleared this cycle, else flags overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_v <= '0;
      wr_v <= '0;
      ovf  <= '0;
      for (int p = 0; p < 2; p++) begin
        rd_addr[p] <= '0;
        wr_addr[p] <= '0;
        wr_data[p] <= '0;
      end
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (rd_in[p]) begin
          if (rd_v[p] && !clr_rd[p]) ovf[p] <= 1'b1;
          else begin
            rd_v[p]    <= 1'b1;
            rd_addr[p] <= addr_in[p];
          end
        end else if (clr_rd[p]) rd_v[p] <= 1'b0;
        if (wr_in[p]) begin
          if (wr_v[p] && !clr_wr[p]) ovf[p] <= 1'b1;
          else begin
            wr_v[p]    <= 1'b1;
            wr_addr[p] <= addr_in[p];
            wr_data[p] <= wdata_in[p];
          end
        end else if (clr_wr[p]) wr_v[p] <= 1'b0;
      end
    end
  end

  // Memory request registers, data-wait counter and fill delivery
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      g_port      <= 1'b0;
      g_we        <= 1'b0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      cnt         <= '0;
      timeout_err <= 1'b0;
      fill_valid  <= '0;
      fill_data[0] <= '0;
      fill_data[1] <= '0;
    end else begin
      fill_valid <= '0;
      if (grant) begin
        g_port   <= sel_port;
        g_we     <= sel_we;
        mem_req  <= 1'b1;
        mem_we   <= sel_we;
        mem_addr <= sel_addr & LINE_MASK;
        if (sel_we) mem_wdata <= wr_data[sel_port];
      end
      if (svc) begin
        mem_req <= 1'b0;
        cnt     <= '0;
      end else if (state == WAIT_DATA && !got && !abort) begin
        cnt <= cnt + 8'd1;
      end
      if (got) fill_data[g_port] <= mem_rdata;
      else if (abort) begin
        fill_data[g_port] <= '0;
        timeout_err       <= 1'b1;
      end
      if (fire) fill_valid[g_port] <= 1'b1;
    end
  end

endmodule

// File: tb/tb_l2_mem_arbiter.sv
// tb/tb_l2_mem_arbiter.sv - directed and randomized self-checking bench for l2_mem_arbiter
module tb_l2_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 128;
  localparam int TO = 4;
`ifdef L2ARB_FIXED_PRIORITY_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } op_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          rd_0 = 0, wr_0 = 0, hold_0 = 0, rd_1 = 0, wr_1 = 0, hold_1 = 0;
  logic [AW-1:0] addr_0 = '0, addr_1 = '0;
  logic [LW-1:0] wdata_0 = '0, wdata_1 = '0;
  logic [LW-1:0] fill_data_0, fill_data_1;
  logic          fill_valid_0, fill_valid_1, ovf_0, ovf_1;
  logic          mem_req, mem_we, timeout_err;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic          mem_ack = 1'b0, mem_rvalid = 1'b0;
  logic [LW-1:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  // memory responder controls and state
  bit            ack_en = 1'b1, rand_lat = 1'b0, rv_drop = 1'b0, fixed_en = 1'b0;
  int            rv_delay = 0;
  logic [LW-1:0] fixed_data = '0;
  bit            rd_pend = 1'b0;
  int            rv_wait = 0, ack_wait = 0;
  logic [AW-1:0] rd_addr_r = '0;
  op_t           resp_op;

  op_t           op_q[$];
  logic [LW-1:0] fq0[$], fq1[$];

  // reference-model working variables
  op_t           exp_q[$];
  op_t           eo;
  bit            pr[2], pw[2];
  logic [AW-1:0] ra[2];
  logic [LW-1:0] wd[2];
  logic [3:0]    m;
  int            m_last, mp, wt, nf;

  l2_mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .rd_0(rd_0), .wr_0(wr_0), .addr_0(addr_0), .wdata_0(wdata_0), .hold_0(hold_0),
    .fill_data_0(fill_data_0), .fill_valid_0(fill_valid_0), .ovf_0(ovf_0),
    .rd_1(rd_1), .wr_1(wr_1), .addr_1(addr_1), .wdata_1(wdata_1), .hold_1(hold_1),
    .fill_data_1(fill_data_1), .fill_valid_1(fill_valid_1), .ovf_1(ovf_1),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  function automatic logic [LW-1:0] rfun(input logic [AW-1:0] a);
    return {a ^ 32'h5A5A_0000, ~a, a, a ^ 32'hC0DE_0000};
  endfunction

  // memory slave: acks requests, logs accepted ops, returns read data
  always @(negedge clk) begin
    mem_ack    = 1'b0;
    mem_rvalid = 1'b0;
    if (rd_pend) begin
      if (rv_wait == 0) begin
        rd_pend = 1'b0;
        if (!rv_drop) begin
          mem_rvalid = 1'b1;
          mem_rdata  = fixed_en ? fixed_data : rfun(rd_addr_r);
        end
      end else rv_wait--;
    end else if (mem_req && ack_en) begin
      if (ack_wait > 0) ack_wait--;
      else begin
        mem_ack      = 1'b1;
        resp_op.we   = mem_we;
        resp_op.addr = mem_addr;
        resp_op.data = mem_wdata;
        op_q.push_back(resp_op);
        if (!mem_we) begin
          rd_pend   = 1'b1;
          rd_addr_r = mem_addr;
          rv_wait   = rand_lat ? int'($urandom_range(0, 2)) : rv_delay;
        end
        ack_wait = rand_lat ? int'($urandom_range(0, 3)) : 0;
      end
    end
  end

  // fill monitor
  always @(negedge clk) begin
    if (fill_valid_0) fq0.push_back(fill_data_0);
    if (fill_valid_1) fq1.push_back(fill_data_1);
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_op(input string tag, input int i, input logic we, input logic [AW-1:0] a,
                        input logic [LW-1:0] d);
    op_t o;
    o.we = 1'bx; o.addr = 'x; o.data = 'x;
    if (i < op_q.size()) o = op_q[i];
    chk({tag, "_we"}, LW'(o.we), LW'(we));
    chk({tag, "_addr"}, LW'(o.addr), LW'(a));
    if (we) chk({tag, "_wdata"}, o.data, d);
  endtask

  task automatic chk_fill(input string tag, input int port, input int i, input logic [LW-1:0] d);
    logic [LW-1:0] v;
    v = 'x;
    if (port == 0 && i < fq0.size()) v = fq0[i];
    else if (port == 1 && i < fq1.size()) v = fq1[i];
    chk(tag, v, d);
  endtask

  task automatic clear_logs();
    op_q.delete();
    fq0.delete();
    fq1.delete();
  endtask

  task automatic drain(input string tag, input int n_ops, input int n0, input int n1);
    int t;
    t = 0;
    while (!(op_q.size() == n_ops && fq0.size() == n0 && fq1.size() == n1) && t < 200) begin
      tick();
      t++;
    end
    repeat (3) tick();
    chk({tag, "_nops"}, LW'(op_q.size()), LW'(n_ops));
    chk({tag, "_nfill0"}, LW'(fq0.size()), LW'(n0));
    chk({tag, "_nfill1"}, LW'(fq1.size()), LW'(n1));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    clear_logs();
  endtask

  initial begin
    // reset values
    tick(); tick();
    chk("rst_mem_req", LW'(mem_req), 0);
    chk("rst_mem_we", LW'(mem_we), 0);
    chk("rst_mem_addr", LW'(mem_addr), 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_fill_v0", LW'(fill_valid_0), 0);
    chk("rst_fill_v1", LW'(fill_valid_1), 0);
    chk("rst_fill_d0", fill_data_0, 0);
    chk("rst_fill_d1", fill_data_1, 0);
    chk("rst_ovf0", LW'(ovf_0), 0);
    chk("rst_ovf1", LW'(ovf_1), 0);
    chk("rst_tmo", LW'(timeout_err), 0);
    reset = 1'b0;
    clear_logs();

    // single read with back-to-back ack and rvalid: fill five cycles after the strobe
    fixed_en = 1'b1;
    fixed_data = {16{8'hA5}};
    rd_0 = 1'b1; addr_0 = 32'h0000_1230;
    tick(); rd_0 = 1'b0;
    chk("rd_c1_req", LW'(mem_req), 0);
    tick();
    chk("rd_c2_req", LW'(mem_req), 1);
    chk("rd_c2_addr", LW'(mem_addr), LW'(32'h0000_1230));
    chk("rd_c2_we", LW'(mem_we), 0);
    tick();
    chk("rd_c3_req", LW'(mem_req), 0);
    tick();
    chk("rd_c4_fv0", LW'(fill_valid_0), 0);
    tick();
    chk("rd_c5_fv0", LW'(fill_valid_0), 1);
    chk("rd_c5_fd0", fill_data_0, {16{8'hA5}});
    chk("rd_c5_fv1", LW'(fill_valid_1), 0);
    chk("rd_c5_fd1", fill_data_1, 0);
    tick();
    chk("rd_c6_fv0", LW'(fill_valid_0), 0);
    fixed_en = 1'b0;
    repeat (2) tick();
    clear_logs();

    // eviction queued behind a busy port-1 read is written before the port-0 fill read
    rd_1 = 1'b1; addr_1 = 32'h3000;
    tick(); rd_1 = 1'b0; rd_0 = 1'b1; addr_0 = 32'h2000;
    tick(); rd_0 = 1'b0; wr_0 = 1'b1; addr_0 = 32'h40; wdata_0 = {16{8'h11}};
    tick(); wr_0 = 1'b0;
    drain("evict", 3, 1, 1);
    chk_op("evict_op0", 0, 1'b0, 32'h3000, '0);
    chk_op("evict_op1", 1, 1'b1, 32'h40, {16{8'h11}});
    chk_op("evict_op2", 2, 1'b0, 32'h2000, '0);
    chk_fill("evict_fill0", 0, 0, rfun(32'h2000));
    chk_fill("evict_fill1", 1, 0, rfun(32'h3000));

    // contention: first tie after reset goes to port 0
    do_reset();
    rd_0 = 1'b1; addr_0 = 32'h100; rd_1 = 1'b1; addr_1 = 32'h200;
    tick(); rd_0 = 1'b0; rd_1 = 1'b0;
    drain("tie1", 2, 1, 1);
    chk_op("tie1_first", 0, 1'b0, 32'h100, '0);
    chk_op("tie1_second", 1, 1'b0, 32'h200, '0);
    clear_logs();
    rd_0 = 1'b1; addr_0 = 32'h300;
    tick(); rd_0 = 1'b0;
    drain("solo0", 1, 1, 0);
    clear_logs();
    rd_0 = 1'b1; addr_0 = 32'h400; rd_1 = 1'b1; addr_1 = 32'h500;
    tick(); rd_0 = 1'b0; rd_1 = 1'b0;
    drain("tie2", 2, 1, 1);
    chk_op("tie2_first", 0, 1'b0, FIXED ? 32'h400 : 32'h500, '0);
    chk_op("tie2_second", 1, 1'b0, FIXED ? 32'h500 : 32'h400, '0);
    clear_logs();

    // hold_1 high for six cycles around the data return defers the fill
    rd_1 = 1'b1; addr_1 = 32'h600;
    for (int c = 1; c <= 10; c++) begin
      tick();
      rd_1 = 1'b0;
      hold_1 = (c >= 2 && c <= 7);
      chk($sformatf("hold_c%0d_fv1", c), LW'(fill_valid_1), LW'(c == 9));
    end
    hold_1 = 1'b0;
    chk_fill("hold_fill1", 1, 0, rfun(32'h600));
    repeat (2) tick();
    clear_logs();

    // overflow: second read strobe while the first is still unacked
    ack_en = 1'b0;
    rd_0 = 1'b1; addr_0 = 32'h700;
    tick(); rd_0 = 1'b0;
    chk("ovf_c1", LW'(ovf_0), 0);
    tick(); rd_0 = 1'b1; addr_0 = 32'h800;
    tick(); rd_0 = 1'b0;
    chk("ovf_c3_ovf0", LW'(ovf_0), 1);
    chk("ovf_c3_ovf1", LW'(ovf_1), 0);
    ack_en = 1'b1;
    drain("ovf", 1, 1, 0);
    chk_op("ovf_op0", 0, 1'b0, 32'h700, '0);
    chk_fill("ovf_fill0", 0, 0, rfun(32'h700));
    chk("ovf_sticky", LW'(ovf_0), 1);
    clear_logs();

    // timeout: read data never returns
    chk("tmo_pre", LW'(timeout_err), 0);
    rv_drop = 1'b1;
    rd_0 = 1'b1; addr_0 = 32'h900;
    tick(); rd_0 = 1'b0;
    wt = 0;
    while (!fill_valid_0 && wt < 30) begin
      tick();
      wt++;
    end
    chk("tmo_pulse", LW'(fill_valid_0), 1);
    chk("tmo_err", LW'(timeout_err), 1);
    chk("tmo_data", fill_data_0, 0);
    rv_drop = 1'b0;
    repeat (2) tick();
    clear_logs();

    // asynchronous reset while a request is outstanding
    ack_en = 1'b0;
    rd_0 = 1'b1; addr_0 = 32'hA00;
    tick(); rd_0 = 1'b0;
    tick();
    chk("rst_issue_req_pre", LW'(mem_req), 1);
    reset = 1'b1;
    #1;
    chk("rst_issue_req", LW'(mem_req), 0);
    chk("rst_issue_tmo", LW'(timeout_err), 0);
    chk("rst_issue_ovf0", LW'(ovf_0), 0);
    tick();
    reset = 1'b0;
    ack_en = 1'b1;
    clear_logs();

    // reset during WAIT_DATA: the late rvalid must not produce a fill
    rv_delay = 3;
    rd_0 = 1'b1; addr_0 = 32'hB00;
    tick(); rd_0 = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    nf = 0;
    repeat (10) begin
      tick();
      if (fill_valid_0) nf++;
    end
    chk("rst_wait_nofill", LW'(nf), 0);
    rv_delay = 0;

    // randomized rounds against the arbitration reference model
    do_reset();
    m_last = 1;
    rand_lat = 1'b1;
    for (int r = 0; r < 30; r++) begin
      clear_logs();
      m = 4'($urandom_range(1, 15));
      for (int p = 0; p < 2; p++) begin
        ra[p] = $urandom;
        wd[p] = {$urandom, $urandom, $urandom, $urandom};
      end
      pr[0] = m[0]; pw[0] = m[1]; pr[1] = m[2]; pw[1] = m[3];
      rd_0 = m[0]; wr_0 = m[1]; addr_0 = ra[0]; wdata_0 = wd[0];
      rd_1 = m[2]; wr_1 = m[3]; addr_1 = ra[1]; wdata_1 = wd[1];
      tick();
      rd_0 = 1'b0; wr_0 = 1'b0; rd_1 = 1'b0; wr_1 = 1'b0;
      exp_q.delete();
      while (pr[0] || pw[0] || pr[1] || pw[1]) begin
        if ((pr[0] || pw[0]) && (pr[1] || pw[1])) mp = FIXED ? 0 : 1 - m_last;
        else mp = (pr[0] || pw[0]) ? 0 : 1;
        eo.addr = ra[mp] & ~32'hF;
        if (pw[mp]) begin
          eo.we = 1'b1; eo.data = wd[mp]; pw[mp] = 1'b0;
        end else begin
          eo.we = 1'b0; eo.data = '0; pr[mp] = 1'b0;
        end
        exp_q.push_back(eo);
        m_last = mp;
      end
      drain($sformatf("rnd%0d", r), exp_q.size(), int'(m[0]), int'(m[2]));
      for (int i = 0; i < exp_q.size(); i++)
        chk_op($sformatf("rnd%0d_op%0d", r, i), i, exp_q[i].we, exp_q[i].addr, exp_q[i].data);
      if (m[0]) chk_fill($sformatf("rnd%0d_fill0", r), 0, 0, rfun(ra[0] & ~32'hF));
      if (m[2]) chk_fill($sformatf("rnd%0d_fill1", r), 1, 0, rfun(ra[1] & ~32'hF));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
